// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner arbiter for the shared core bus.
// Holds a grant for the whole transaction, then inserts one turnaround cycle.
// Revokes a grant that is never used. Define BUS_ARB_LOCK_EN to add in_lock,
// which lets an owner keep the bus for back-to-back transactions.
module bus_rr_arbiter #(
  parameter int NUM_REQ       = 6,
  parameter int IDX_WIDTH     = 3,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   in_reqcyc,
  input  logic                 in_bus_busy,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   in_lock,
`endif
  output logic [NUM_REQ-1:0]   out_grant,
  output logic                 out_owner_valid,
  output logic [IDX_WIDTH-1:0] out_owner_idx,
  output logic                 out_timeout
);
  localparam int NP = 2 ** IDX_WIDTH;
  localparam int PW = IDX_WIDTH + 1;
  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} state_t;

  state_t                 state, state_d;
  logic [NUM_REQ-1:0]     grant, grant_d;
  logic [IDX_WIDTH-1:0]   owner, owner_d;
  logic [IDX_WIDTH-1:0]   rr_ptr, ptr_d;
  logic [TW-1:0]          timer, timer_d;
  logic                   timeout, timeout_d;
  logic                   rel;
  logic                   found;
  logic [IDX_WIDTH-1:0]   sel;
  logic [PW-1:0]          pos;
  logic [NP-1:0]          req_pad;
`ifdef BUS_ARB_LOCK_EN
  logic [NP-1:0]          lock_pad;
  logic [2:0]             lock_cnt, lock_cnt_d;
  assign lock_pad = NP'(in_lock);
`endif

  // Pad requests so any owner-index value addresses a defined bit.
  assign req_pad = NP'(in_reqcyc);

  assign out_grant       = grant;
  assign out_owner_valid = |grant;
  assign out_owner_idx   = owner;
  assign out_timeout     = timeout;

  // First requesting index at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + PW'(i);
      pos = (pos >= PW'(NUM_REQ)) ? pos - PW'(NUM_REQ) : pos;
      if (!found && req_pad[pos[IDX_WIDTH-1:0]]) begin
        found = 1'b1;
        sel   = pos[IDX_WIDTH-1:0];
      end
    end
  end

  // Next-state and next-output logic for the grant lifecycle.
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    owner_d    = owner;
    ptr_d      = rr_ptr;
    timer_d    = timer;
    timeout_d  = 1'b0;
    rel        = 1'b0;
`ifdef BUS_ARB_LOCK_EN
    lock_cnt_d = lock_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_d    = GRANTED;
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
          owner_d    = sel;
          timer_d    = '0;
`ifdef BUS_ARB_LOCK_EN
          lock_cnt_d = '0;
`endif
        end
      end
      GRANTED: begin
        if (in_bus_busy)
          state_d = BUSY;
        else if (!req_pad[owner])
          rel = 1'b1;
        else if (GRANT_TIMEOUT > 0 && timer == T_LAST) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else
          timer_d = timer + 1'b1;
      end
      BUSY: begin
        if (!in_bus_busy) begin
`ifdef BUS_ARB_LOCK_EN
          if (lock_pad[owner] && lock_cnt != 3'd4) begin
            state_d    = GRANTED;
            timer_d    = '0;
            lock_cnt_d = lock_cnt + 1'b1;
          end else
            rel = 1'b1;
`else
          rel = 1'b1;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d = RELEASE;
      grant_d = '0;
      owner_d = '0;
      ptr_d   = (owner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      timer    <= '0;
      timeout  <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      owner    <= owner_d;
      rr_ptr   <= ptr_d;
      timer    <= timer_d;
      timeout  <= timeout_d;
`ifdef BUS_ARB_LOCK_EN
      lock_cnt <= lock_cnt_d;
`endif
    end
  end
endmodule
